stopwatch_timer: RTL and testbench
==================================

// Module: stopwatch_timer
// PURPOSE
//  Parametrised successor to the lab3 stopwatch counter: a BCD mm..m:ss up/down timer.
//  Single clock domain: 1 Hz and 2 Hz arrive as one-cycle enables, not as derived clocks.
//  Adds countdown with expiry, preset load, toggle-pause and lap capture.
//  Sits between the tick generator / debouncers and the 7-segment display mux.
// PARAMETERS
//  MIN_DIGITS  2  number of BCD minute digits, legal 1..4; minutes wrap at 10^MIN_DIGITS
//  LAP_EN      1  1 = lap capture logic present; 0 = lap_* outputs tied to 0
// PORTS
//  clk        in   1              system clock; sole clock
//  rst        in   1              synchronous, active-low reset
//  tick_run   in   1              1 Hz enable pulse, one clk wide
//  tick_adj   in   1              2 Hz enable pulse, one clk wide
//  mode_down  in   1              0 = count up, 1 = count down (run mode only)
//  adj        in   1              1 = adjust mode, steps on tick_adj
//  sel        in   1              adjust target: 0 = minutes, 1 = seconds
//  pause_btn  in   1              debounced one-cycle pulse; toggles run/pause
//  load       in   1              one-cycle pulse; presets count from load_min/load_sec
//  load_min   in   4*MIN_DIGITS   BCD minutes preset, MS digit in top nibble
//  load_sec   in   8              BCD seconds preset, [7:4] tens, [3:0] ones
//  lap_btn    in   1              one-cycle pulse; snapshot current count
//  min_bcd    out  4*MIN_DIGITS   current minutes, BCD
//  sec_bcd    out  8              current seconds, BCD
//  lap_min    out  4*MIN_DIGITS   captured minutes
//  lap_sec    out  8              captured seconds
//  lap_valid  out  1              lap registers hold a capture
//  paused     out  1              1 in PAUSED state
//  expired    out  1              1 in EXPIRED state
// BEHAVIOUR
//  FSM states: PAUSED, RUN, EXPIRED.
//  Reset (rst==0 at posedge clk):
//   - state = PAUSED
//   - all count digits and lap registers = 0
//   - lap_valid = 0, expired = 0, paused = 1
//  Priority within one cycle: reset > load > adjust step > run step.
//   - pause_btn and lap_btn are evaluated alongside the step.
//  All decisions use registered state. Outputs change 1 clk after the qualifying input cycle.
//  Run step (adj==0, state==RUN, tick_run==1):
//   - Up: sec ones 0..9, sec tens 0..5, carry into minutes; all-9s:59 wraps to all-0:00.
//   - Down: borrow chain is the mirror of up.
//   - Down at 00:00: count holds at zero, state -> EXPIRED (no wrap).
//  Adjust step (adj==1, tick_adj==1):
//   - Allowed in PAUSED and RUN; tick_run is ignored while adj==1.
//   - Always increments, regardless of mode_down.
//   - sel==0: minutes field +1, wraps to 0; seconds unchanged.
//   - sel==1: seconds +1, 59 -> 00, no carry into minutes.
//  Adjust in EXPIRED: moves the state to PAUSED and applies the step; expired clears.
//  pause_btn transitions: RUN <-> PAUSED; EXPIRED -> PAUSED (expired clears).
//  pause_btn + tick_run in the same cycle while RUN: step applies and state -> PAUSED.
//  load:
//   - Valid preset: every digit <= 9 and sec tens <= 5.
//   - Valid: count takes the preset, state -> PAUSED, expired = 0, lap_valid = 0.
//   - Invalid: the whole load is ignored.
//   - load pre-empts any tick or adjust step in the same cycle.
//  lap_btn (LAP_EN==1):
//   - lap regs take the count as it stands before any same-cycle step; lap_valid = 1.
//   - Works in any state; a later lap_btn overwrites the capture.
//  Digits never hold a non-BCD value; no internal counter wider than a digit nibble.
// TESTING
//  1. rst=0 one clk -> count 00:00, paused=1, expired=0, lap_valid=0.
//  2. Up, RUN, 09:59 preset + tick_run -> 10:00; 99:59 + tick_run -> 00:00.
//  3. Down from preset 00:02, 3 tick_run -> 00:01, 00:00, expired=1 with count held;
//     pause_btn -> paused=1, expired=0.
//  4. adj=1 sel=1 at 12:59 + tick_adj -> 12:00; sel=0 at 99:30 -> 00:30;
//     tick_run ignored throughout.
//  5. Same cycle lap_btn + tick_run at 05:09 -> lap = 05:09, count 05:10;
//     load 07:61 -> ignored; load 07:45 -> count 07:45, lap_valid=0.
//  6. MIN_DIGITS=3 at 999:59 + tick_run -> 000:00; LAP_EN=0 -> lap outputs stay 0.

Source files
------------

// File: rtl/stopwatch_timer.sv
// BCD mm..m:ss up/down stopwatch with countdown expiry,
// preset load, toggle-pause and lap capture.
module stopwatch_timer #(
  parameter int MIN_DIGITS = 2,
  parameter bit LAP_EN     = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick_run,
  input  logic                    tick_adj,
  input  logic                    mode_down,
  input  logic                    adj,
  input  logic                    sel,
  input  logic                    pause_btn,
  input  logic                    load,
  input  logic [4*MIN_DIGITS-1:0] load_min,
  input  logic [7:0]              load_sec,
  input  logic                    lap_btn,
  output logic [4*MIN_DIGITS-1:0] min_bcd,
  output logic [7:0]              sec_bcd,
  output logic [4*MIN_DIGITS-1:0] lap_min,
  output logic [7:0]              lap_sec,
  output logic                    lap_valid,
  output logic                    paused,
  output logic                    expired
);

  localparam int MW = 4*MIN_DIGITS;

  typedef enum logic [1:0] {
    S_PAUSED  = 2'd0,
    S_RUN     = 2'd1,
    S_EXPIRED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [MW-1:0] min_q, min_d;
  logic [7:0]    sec_q, sec_d;
  logic [8:0]    sc;
  logic          load_ok, do_load;
  logic          adj_step, run_step;
  logic          at_zero, down_zero;

  function automatic logic [MW-1:0] min_inc(input logic [MW-1:0] m);
    logic [MW-1:0] r;
    logic          c;
    r = m;
    c = 1'b1;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      if (c) begin
        if (m[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = m[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [MW-1:0] min_dec(input logic [MW-1:0] m);
    logic [MW-1:0] r;
    logic          b;
    r = m;
    b = 1'b1;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      if (b) begin
        if (m[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = m[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // {carry, tens, ones}
  function automatic logic [8:0] sec_inc(input logic [7:0] s);
    if (s[3:0] != 4'd9) return {1'b0, s[7:4], s[3:0] + 4'd1};
    if (s[7:4] != 4'd5) return {1'b0, s[7:4] + 4'd1, 4'd0};
    return 9'h100;
  endfunction

  // {borrow, tens, ones}
  function automatic logic [8:0] sec_dec(input logic [7:0] s);
    if (s[3:0] != 4'd0) return {1'b0, s[7:4], s[3:0] - 4'd1};
    if (s[7:4] != 4'd0) return {1'b0, s[7:4] - 4'd1, 4'd9};
    return {1'b1, 4'd5, 4'd9};
  endfunction

  // preset legality: every digit BCD, seconds tens at most 5
  always_comb begin
    load_ok = (load_sec[7:4] <= 4'd5) && (load_sec[3:0] <= 4'd9);
    for (int i = 0; i < MIN_DIGITS; i++) begin
      if (load_min[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
  end

  assign do_load   = load & load_ok;
  assign adj_step  = adj & tick_adj;
  assign run_step  = ~adj & tick_run & (state_q == S_RUN);
  assign at_zero   = (min_q == '0) && (sec_q == 8'h00);
  assign down_zero = run_step & mode_down & at_zero;

  // state and count registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_PAUSED;
      min_q   <= '0;
      sec_q   <= '0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
    end
  end

  // next state: load forces pause, pause toggles, countdown expiry
  always_comb begin
    state_d = state_q;
    if (do_load) begin
      state_d = S_PAUSED;
    end else begin
      case (state_q)
        S_RUN: begin
          if (pause_btn)      state_d = S_PAUSED;
          else if (down_zero) state_d = S_EXPIRED;
        end
        S_PAUSED: begin
          if (pause_btn) state_d = S_RUN;
        end
        S_EXPIRED: begin
          if (pause_btn || adj_step) state_d = S_PAUSED;
        end
        default: state_d = S_PAUSED;
      endcase
    end
  end

  // next count: load > adjust step > run step
  always_comb begin
    min_d = min_q;
    sec_d = sec_q;
    sc    = '0;
    if (do_load) begin
      min_d = load_min;
      sec_d = load_sec;
    end else if (adj_step) begin
      if (sel) begin
        sc    = sec_inc(sec_q);
        sec_d = sc[7:0];
      end else begin
        min_d = min_inc(min_q);
      end
    end else if (run_step && !down_zero) begin
      sc    = mode_down ? sec_dec(sec_q) : sec_inc(sec_q);
      sec_d = sc[7:0];
      if (sc[8]) min_d = mode_down ? min_dec(min_q) : min_inc(min_q);
    end
  end

  // status outputs decoded from registered state
  always_comb begin
    paused  = 1'b0;
    expired = 1'b0;
    case (state_q)
      S_PAUSED:  paused  = 1'b1;
      S_EXPIRED: expired = 1'b1;
      default: ;
    endcase
  end

  assign min_bcd = min_q;
  assign sec_bcd = sec_q;

  generate
    if (LAP_EN) begin : g_lap
      logic [MW-1:0] lmin_q;
      logic [7:0]    lsec_q;
      logic          lv_q;
      // snapshot of the pre-step count; a valid load drops it
      always_ff @(posedge clk) begin
        if (!rst) begin
          lmin_q <= '0;
          lsec_q <= '0;
          lv_q   <= 1'b0;
        end else if (do_load) begin
          lv_q   <= 1'b0;
        end else if (lap_btn) begin
          lmin_q <= min_q;
          lsec_q <= sec_q;
          lv_q   <= 1'b1;
        end
      end
      assign lap_min   = lmin_q;
      assign lap_sec   = lsec_q;
      assign lap_valid = lv_q;
    end else begin : g_nolap
      logic unused_lap;
      assign unused_lap = lap_btn;
      assign lap_min    = '0;
      assign lap_sec    = '0;
      assign lap_valid  = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_stopwatch_timer.sv
// Randomised bench for stopwatch_timer against a
// seconds-arithmetic reference model.
module tb_stopwatch_timer;

  localparam int MD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          tick_run = 0, tick_adj = 0;
  logic          mode_down = 0, adj = 0, sel = 0;
  logic          pause_btn = 0, load = 0, lap_btn = 0;
  logic [4*MD-1:0] load_min = '0;
  logic [7:0]    load_sec = '0;
  logic [4*MD-1:0] min_bcd, lap_min;
  logic [7:0]    sec_bcd, lap_sec;
  logic          lap_valid, paused, expired;

  logic          rst3 = 1'b1;
  logic          tick3 = 0, pause3 = 0, load3 = 0, lap3 = 0;
  logic [11:0]   lmin3 = '0;
  logic [7:0]    lsec3 = '0;
  logic [11:0]   min3, lapm3;
  logic [7:0]    sec3, laps3;
  logic          lapv3, paused3, expired3;

  stopwatch_timer #(.MIN_DIGITS(MD), .LAP_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .tick_run(tick_run), .tick_adj(tick_adj),
    .mode_down(mode_down), .adj(adj), .sel(sel),
    .pause_btn(pause_btn), .load(load), .load_min(load_min),
    .load_sec(load_sec), .lap_btn(lap_btn),
    .min_bcd(min_bcd), .sec_bcd(sec_bcd),
    .lap_min(lap_min), .lap_sec(lap_sec), .lap_valid(lap_valid),
    .paused(paused), .expired(expired)
  );

  stopwatch_timer #(.MIN_DIGITS(3), .LAP_EN(1'b0)) u_dut3 (
    .clk(clk), .rst(rst3), .tick_run(tick3), .tick_adj(1'b0),
    .mode_down(1'b0), .adj(1'b0), .sel(1'b0),
    .pause_btn(pause3), .load(load3), .load_min(lmin3),
    .load_sec(lsec3), .lap_btn(lap3),
    .min_bcd(min3), .sec_bcd(sec3),
    .lap_min(lapm3), .lap_sec(laps3), .lap_valid(lapv3),
    .paused(paused3), .expired(expired3)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // reference model: plain integers, minutes 0..99, seconds 0..59
  int m_min, m_sec, l_min, l_sec;
  bit m_paused, m_expired, l_valid;

  function automatic int bcd2(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] tobcd(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  function automatic bit lvalid(input logic [7:0] mn,
                                input logic [7:0] sc);
    return mn[7:4] < 10 && mn[3:0] < 10 &&
           sc[7:4] < 6 && sc[3:0] < 10;
  endfunction

  task automatic model_step();
    bit run0, pau0, adjs, runs, exp_now;
    int t;
    if (!rst) begin
      m_min = 0; m_sec = 0; l_min = 0; l_sec = 0;
      m_paused = 1; m_expired = 0; l_valid = 0;
      return;
    end
    if (load && lvalid(load_min, load_sec)) begin
      m_min = bcd2(load_min);
      m_sec = bcd2(load_sec);
      m_paused = 1; m_expired = 0; l_valid = 0;
      return;
    end
    run0 = !m_paused && !m_expired;
    pau0 = m_paused;
    if (lap_btn) begin
      l_min = m_min; l_sec = m_sec; l_valid = 1;
    end
    adjs = adj && tick_adj;
    runs = !adj && tick_run && run0;
    exp_now = 0;
    if (adjs) begin
      if (sel) m_sec = (m_sec + 1) % 60;
      else     m_min = (m_min + 1) % 100;
    end else if (runs) begin
      t = m_min * 60 + m_sec;
      if (!mode_down)  t = (t + 1) % 6000;
      else if (t == 0) exp_now = 1;
      else             t = t - 1;
      m_min = t / 60;
      m_sec = t % 60;
    end
    if (run0) begin
      if (pause_btn)    m_paused = 1;
      else if (exp_now) m_expired = 1;
    end else if (pau0) begin
      if (pause_btn) m_paused = 0;
    end else if (pause_btn || adjs) begin
      m_expired = 0; m_paused = 1;
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("min", min_bcd, tobcd(m_min));
    chk("sec", sec_bcd, tobcd(m_sec));
    chk("paused", paused, m_paused);
    chk("expired", expired, m_expired);
    chk("lap_valid", lap_valid, l_valid);
    chk("lap_min", lap_min, tobcd(l_min));
    chk("lap_sec", lap_sec, tobcd(l_sec));
    rst = 1; tick_run = 0; tick_adj = 0;
    pause_btn = 0; load = 0; lap_btn = 0;
    rst3 = 1; tick3 = 0; pause3 = 0; load3 = 0; lap3 = 0;
  endtask

  task automatic ld(input logic [7:0] mn, input logic [7:0] sc);
    load = 1; load_min = mn; load_sec = sc;
    cyc();
  endtask

  initial begin
    #1;
    rst = 0; cyc();
    chk("rst_min", min_bcd, 8'h00);
    chk("rst_sec", sec_bcd, 8'h00);
    chk("rst_paused", paused, 1);
    chk("rst_expired", expired, 0);
    chk("rst_lapv", lap_valid, 0);

    mode_down = 0;
    ld(8'h09, 8'h59);
    pause_btn = 1; cyc();
    chk("run_state", paused, 0);
    tick_run = 1; cyc();
    chk("up_carry_min", min_bcd, 8'h10);
    chk("up_carry_sec", sec_bcd, 8'h00);
    ld(8'h99, 8'h59);
    pause_btn = 1; cyc();
    tick_run = 1; cyc();
    chk("up_wrap_min", min_bcd, 8'h00);
    chk("up_wrap_sec", sec_bcd, 8'h00);

    mode_down = 1;
    ld(8'h00, 8'h02);
    pause_btn = 1; cyc();
    tick_run = 1; cyc();
    chk("dn_1", sec_bcd, 8'h01);
    tick_run = 1; cyc();
    chk("dn_0", sec_bcd, 8'h00);
    chk("dn_0_notexp", expired, 0);
    tick_run = 1; cyc();
    chk("exp_set", expired, 1);
    chk("exp_hold_sec", sec_bcd, 8'h00);
    chk("exp_hold_min", min_bcd, 8'h00);
    pause_btn = 1; cyc();
    chk("exp_pause_p", paused, 1);
    chk("exp_pause_e", expired, 0);

    mode_down = 0;
    ld(8'h12, 8'h59);
    pause_btn = 1; cyc();
    adj = 1; sel = 1; tick_adj = 1; tick_run = 1; cyc();
    chk("adj_sec_min", min_bcd, 8'h12);
    chk("adj_sec_sec", sec_bcd, 8'h00);
    tick_run = 1; cyc();
    chk("adj_ign_run", sec_bcd, 8'h00);
    ld(8'h99, 8'h30);
    pause_btn = 1; cyc();
    sel = 0; tick_adj = 1; tick_run = 1; cyc();
    chk("adj_min_min", min_bcd, 8'h00);
    chk("adj_min_sec", sec_bcd, 8'h30);
    adj = 0;

    ld(8'h05, 8'h09);
    pause_btn = 1; cyc();
    lap_btn = 1; tick_run = 1; cyc();
    chk("lap_min_cap", lap_min, 8'h05);
    chk("lap_sec_cap", lap_sec, 8'h09);
    chk("lap_v_set", lap_valid, 1);
    chk("lap_step_sec", sec_bcd, 8'h10);
    ld(8'h07, 8'h61);
    chk("bad_load_sec", sec_bcd, 8'h10);
    chk("bad_load_run", paused, 0);
    chk("bad_load_lapv", lap_valid, 1);
    ld(8'h07, 8'h45);
    chk("load_min", min_bcd, 8'h07);
    chk("load_sec", sec_bcd, 8'h45);
    chk("load_lapv", lap_valid, 0);
    chk("load_paused", paused, 1);

    rst3 = 0; cyc();
    chk("d3_rst_min", min3, 12'h000);
    lmin3 = 12'h999; lsec3 = 8'h59; load3 = 1; cyc();
    chk("d3_load_min", min3, 12'h999);
    pause3 = 1; cyc();
    lap3 = 1; tick3 = 1; cyc();
    chk("d3_wrap_min", min3, 12'h000);
    chk("d3_wrap_sec", sec3, 8'h00);
    chk("d3_run", paused3, 0);
    chk("d3_lapm", lapm3, 12'h000);
    chk("d3_laps", laps3, 8'h00);
    chk("d3_lapv", lapv3, 0);

    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 499) != 0);
      tick_run  = ($urandom_range(0, 2) == 0);
      tick_adj  = ($urandom_range(0, 3) == 0);
      pause_btn = ($urandom_range(0, 9) == 0);
      lap_btn   = ($urandom_range(0, 9) == 0);
      sel       = $urandom_range(0, 1);
      if ($urandom_range(0, 19) == 0) adj = ~adj;
      if ($urandom_range(0, 49) == 0) mode_down = ~mode_down;
      load = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 1) == 0) begin
        load_min = 8'h00;
        load_sec = {4'd0, 4'($urandom_range(0, 3))};
      end else begin
        load_min = {4'($urandom_range(0, 10)), 4'($urandom_range(0, 10))};
        load_sec = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 10))};
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
